mm_wait_responder: RTL and testbench

//  Responder (slave) end of the CPU data/instruction memory interface: services

---
 rtl/mm_pkg.sv | 18 +
 rtl/mm_ram_core.sv | 31 +++
 rtl/mm_wait_responder.sv | 150 +++++++++++++++
 tb/tb_mm_wait_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared definitions for the wait-state memory responder.
//   MM_DATA_W  : data path width (32)
//   MM_RD/MM_WR: Ctrl request encodings (2'b00 / 2'b11 mean no request)
//   mm_state_t : responder FSM states IDLE -> WAIT -> RESP
package mm_pkg;

   localparam int unsigned MM_DATA_W = 32;

   localparam logic [1:0] MM_RD = 2'b01;
   localparam logic [1:0] MM_WR = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mm_state_t;

endpackage

// File: rtl/mm_ram_core.sv
// mm_ram_core: synchronous single-port RAM, 2**ADDR_W words of MM_DATA_W bits.
//   clk   in  clock
//   we    in  write enable (wdata -> mem[addr] on rising edge)
//   re    in  read enable (mem[addr] -> rdata on rising edge)
//   addr  in  word address
//   wdata in  write data
//   rdata out registered read data, holds between reads
// Contents are never cleared.
module mm_ram_core
   import mm_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic                 re,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [MM_DATA_W-1:0] wdata,
   output logic [MM_DATA_W-1:0] rdata
);

   logic [MM_DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      if (re)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/mm_wait_responder.sv
// mm_wait_responder: responder end of the CPU memory interface. Accepts a
// read/write request from IDLE, waits WAIT_STATES cycles, then completes with
// a one-cycle Ready pulse (Err valid alongside it).
//   CLK     in   clock
//   RST_n   in   synchronous active-low reset
//   Ctrl    in   2'b01 read, 2'b10 write, others no request
//   Addr    in   byte address
//   W_data  in   write data
//   R_data  out  read data, held until the next read completes
//   Ready   out  one-cycle completion pulse
//   Err     out  error flag, qualified by Ready
//   Busy    out  high whenever the FSM is not IDLE
// Build option: define MM_ALIGN_CHECK_EN to flag Addr[1:0] != 0 as an error.
module mm_wait_responder
   import mm_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic [1:0]  Ctrl,
   input  logic [31:0] Addr,
   input  logic [31:0] W_data,
   output logic [31:0] R_data,
   output logic        Ready,
   output logic        Err,
   output logic        Busy
);

   localparam int unsigned CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mm_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic        rd_zero;

   logic        req_valid;
   logic        access;
   logic [1:0]  cur_op;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic        out_of_range;
   logic        misalign;
   logic        acc_err;
   logic        ram_we;
   logic        ram_re;
   logic [MM_DATA_W-1:0] ram_rdata;

   assign req_valid = (Ctrl == MM_RD) || (Ctrl == MM_WR);

   // The RAM access happens on the edge that enters RESP. With zero wait
   // states that is the accept edge itself, so the live inputs are used while
   // IDLE and the latched request otherwise.
   assign cur_op    = (state == IDLE) ? Ctrl   : op_q;
   assign cur_addr  = (state == IDLE) ? Addr   : addr_q;
   assign cur_wdata = (state == IDLE) ? W_data : wdata_q;

   assign out_of_range = |cur_addr[31:ADDR_W+2];

`ifdef MM_ALIGN_CHECK_EN
   assign misalign = |cur_addr[1:0];
`else
   logic unused_lsb;
   assign unused_lsb = ^cur_addr[1:0];
   assign misalign   = 1'b0;
`endif

   assign acc_err = out_of_range | misalign;

   always_comb begin
      state_nxt = state;
      access    = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (WAIT_STATES == 0) begin
                  state_nxt = RESP;
                  access    = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == CNT_ONE) begin
               state_nxt = RESP;
               access    = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Gated by RST_n so a reset landing on the RESP-entry edge aborts the write.
   assign ram_we = RST_n & access & (cur_op == MM_WR) & ~acc_err;
   assign ram_re = RST_n & access & (cur_op == MM_RD) & ~acc_err;

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state   <= IDLE;
         cnt     <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rd_zero <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state == IDLE && req_valid) begin
            op_q    <= Ctrl;
            addr_q  <= Addr;
            wdata_q <= W_data;
            cnt     <= CNT_INIT;
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CNT_ONE;
         end
         if (access) begin
            err_q <= acc_err;
            // A failed read must show zero while the RAM register keeps its
            // last good value; a write leaves the read result untouched.
            if (cur_op == MM_RD)
               rd_zero <= acc_err;
         end
      end
   end

   mm_ram_core #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (CLK),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (cur_addr[ADDR_W+1:2]),
      .wdata (cur_wdata),
      .rdata (ram_rdata)
   );

   assign Busy   = (state != IDLE);
   assign Ready  = (state == RESP);
   assign Err    = Ready & err_q;
   assign R_data = rd_zero ? '0 : ram_rdata;

endmodule

// File: tb/tb_mm_wait_responder.sv
// Bench for mm_wait_responder: one instance with two wait states, one with
// none, both driven against a word-level memory model.
module tb_mm_wait_responder;
   import mm_pkg::*;

   logic             CLK = 1'b0;
   logic             RST_n;
   logic [1:0][1:0]  ctrl;
   logic [1:0][31:0] addr;
   logic [1:0][31:0] wdata;
   logic [1:0][31:0] rdata;
   logic [1:0]       rdy;
   logic [1:0]       err;
   logic [1:0]       busy;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [31:0] mdl [int];
   logic [31:0] last_rd [2];

   always #5 CLK = ~CLK;

   mm_wait_responder #(.ADDR_W(10), .WAIT_STATES(2)) u_ws2 (
      .CLK(CLK), .RST_n(RST_n), .Ctrl(ctrl[0]), .Addr(addr[0]), .W_data(wdata[0]),
      .R_data(rdata[0]), .Ready(rdy[0]), .Err(err[0]), .Busy(busy[0])
   );

   mm_wait_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_ws0 (
      .CLK(CLK), .RST_n(RST_n), .Ctrl(ctrl[1]), .Addr(addr[1]), .W_data(wdata[1]),
      .R_data(rdata[1]), .Ready(rdy[1]), .Err(err[1]), .Busy(busy[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic int ws_of(input int idx);
      return (idx == 0) ? 2 : 0;
   endfunction

   // 1024 words of 4 bytes -> byte addresses at or above 4096 are invalid.
   function automatic bit exp_err(input logic [31:0] a);
      bit e;
      e = (a >= 32'd4096);
`ifdef MM_ALIGN_CHECK_EN
      if ((a % 4) != 0) e = 1'b1;
`endif
      return e;
   endfunction

   function automatic int key_of(input int idx, input logic [31:0] a);
      return idx * 4096 + int'(a / 4);
   endfunction

   // Issues one request from IDLE, holds it until Ready, checks the result,
   // then checks that the next cycle is IDLE again.
   task automatic xfer(input int idx, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input bit noise, input string tag);
      int n;
      bit busy_ok;
      bit e;
      logic [31:0] exp_r;
      @(negedge CLK);
      ctrl[idx]  = op;
      addr[idx]  = a;
      wdata[idx] = d;
      n = 0;
      busy_ok = 1'b1;
      do begin
         @(posedge CLK); #1;
         n++;
         if (!busy[idx]) busy_ok = 1'b0;
         if (noise && !rdy[idx]) begin
            ctrl[idx]  = MM_WR;
            addr[idx]  = 32'h3C;
            wdata[idx] = $urandom;
         end
      end while (!rdy[idx] && n < 16);
      e = exp_err(a);
      check({tag, "_lat"},  n, ws_of(idx) + 1);
      check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
      check({tag, "_err"},  {31'b0, err[idx]}, {31'b0, e});
      if (op == MM_RD) begin
         exp_r = e ? 32'h0 : mdl[key_of(idx, a)];
         check({tag, "_rdata"}, rdata[idx], exp_r);
         last_rd[idx] = exp_r;
      end else begin
         check({tag, "_hold"}, rdata[idx], last_rd[idx]);
         if (!e) mdl[key_of(idx, a)] = d;
      end
      ctrl[idx] = 2'b00;
      @(posedge CLK); #1;
      check({tag, "_idle"}, {30'b0, busy[idx], rdy[idx]}, 32'd0);
   endtask

   initial begin
      int pulses[$];
      logic [31:0] a;
      logic [1:0]  op;
      int idx;
      int r;

      RST_n = 1'b0;
      ctrl  = '0;
      addr  = '0;
      wdata = '0;
      repeat (3) @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++)
         check($sformatf("reset%0d", i), {rdata[i] | {29'b0, rdy[i], err[i], busy[i]}}, 32'd0);
      RST_n = 1'b1;
      last_rd[0] = '0;
      last_rd[1] = '0;

      // give every word the random phase can touch a known value
      for (int i = 0; i < 2; i++)
         for (int w = 0; w < 16; w++)
            xfer(i, MM_WR, 32'(w * 4), $urandom, 1'b0, "init");

      xfer(0, MM_WR, 32'h10, 32'hDEADBEEF, 1'b0, "t1_wr");
      xfer(0, MM_RD, 32'h10, 32'h0, 1'b0, "t1_rd");

      xfer(0, MM_RD, 32'h1000, 32'h0, 1'b0, "t2_rd");
      xfer(0, MM_WR, 32'h1000, 32'h12345678, 1'b0, "t2_wr");
      xfer(0, MM_RD, 32'h0, 32'h0, 1'b0, "t2_alias");

      xfer(0, MM_WR, 32'h12, 32'hA5A5A5A5, 1'b0, "t3_wr");
      xfer(0, MM_RD, 32'h10, 32'h0, 1'b0, "t3_rd");

      xfer(0, MM_WR, 32'h14, 32'hCAFEF00D, 1'b1, "t4_wr");
      xfer(0, MM_RD, 32'h3C, 32'h0, 1'b0, "t4_rd_other");
      xfer(0, MM_RD, 32'h14, 32'h0, 1'b0, "t4_rd");

      // reset lands on the edge that would have committed the write
      xfer(0, MM_WR, 32'h20, 32'h55, 1'b0, "t5_pre");
      @(negedge CLK);
      ctrl[0] = MM_WR; addr[0] = 32'h20; wdata[0] = 32'h1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST_n   = 1'b0;
      ctrl[0] = 2'b00;
      @(posedge CLK); #1;
      check("t5_rst", {rdata[0] | {29'b0, rdy[0], err[0], busy[0]}}, 32'd0);
      RST_n = 1'b1;
      last_rd[0] = '0;
      last_rd[1] = '0;
      xfer(0, MM_RD, 32'h20, 32'h0, 1'b0, "t5_rd");

      xfer(1, MM_RD, 32'h10, 32'h0, 1'b0, "t6_rd");
      // request held continuously: RESP, one IDLE cycle, then the next accept
      @(negedge CLK);
      ctrl[1] = MM_RD; addr[1] = 32'h10;
      for (int c = 0; c < 9; c++) begin
         @(posedge CLK); #1;
         if (rdy[1]) pulses.push_back(c);
      end
      ctrl[1] = 2'b00;
      @(posedge CLK); #1;
      check("t6_npulse", pulses.size(), 32'd5);
      for (int k = 1; k < pulses.size(); k++)
         check($sformatf("t6_gap%0d", k), pulses[k] - pulses[k-1], ws_of(1) + 2);
      check("t6_rdata", rdata[1], mdl[key_of(1, 32'h10)]);
      last_rd[1] = mdl[key_of(1, 32'h10)];

      for (int t = 0; t < 80; t++) begin
         idx = $urandom_range(0, 1);
         op  = $urandom_range(0, 1) ? MM_RD : MM_WR;
         r   = $urandom_range(0, 9);
         a   = 32'($urandom_range(0, 15) * 4);
         if (r == 0)
            a = $urandom | 32'h1000;
         else if (r == 1)
            a = a + 32'($urandom_range(1, 3));
         xfer(idx, op, a, $urandom, 1'b0, $sformatf("rnd%0d", t));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
